// File: rtl/button_event_parser.sv
// Multi-channel button parser: 2-flop sync, tick-gated debounce, per-channel press FSM.
// Latency: Level follows In after 2 + 2^debwidth enabled ticks; events one clock after the Level edge/tick.
// No backpressure: events are single-cycle pulses with no handshake and are lost if not sampled.
module button_event_parser #(
   parameter int width       = 1,
   parameter int debwidth    = 16,
   parameter int holdwidth   = 16,
   parameter int holdticks   = 1000,
   parameter int repeatticks = 200,
   parameter int repeaten    = 1,
   parameter int related     = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [width-1:0] In,
   output logic [width-1:0] Level,
   output logic [width-1:0] Active,
   output logic [width-1:0] Press,
   output logic [width-1:0] Release,
   output logic [width-1:0] LongPress,
   output logic [width-1:0] Repeat
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRESSED = 3'd1,
      ST_HELD    = 3'd2,
      ST_REPEAT  = 3'd3,
      ST_LOCKED  = 3'd4
   } state_t;

   // Terminal counts: the event fires on the tick that sees the counter at N-1.
   localparam logic [holdwidth-1:0] hold_last   = holdwidth'(holdticks - 1);
   localparam logic [holdwidth-1:0] repeat_last = holdwidth'(repeatticks - 1);
   localparam logic [debwidth-1:0]  deb_full    = {debwidth{1'b1}};

   logic [width-1:0]     s1;
   logic [width-1:0]     s2;
   logic [width-1:0]     level_prev;
   logic [debwidth-1:0]  cnt [width];

   logic [width-1:0]     rise;
   logic [width-1:0]     fall;
   logic [width-1:0]     accept;
   logic                 any_active;
   logic                 lower_rise;

   state_t               state   [width];
   state_t               state_n [width];
   logic [holdwidth-1:0] hcnt    [width];
   logic [holdwidth-1:0] hcnt_n  [width];

   logic [width-1:0]     active_n;
   logic [width-1:0]     press_n;
   logic [width-1:0]     release_n;
   logic [width-1:0]     longpress_n;
   logic [width-1:0]     repeat_n;

   // Two-flop synchroniser for the raw asynchronous buttons, runs every clock.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= In;
         s2 <= s1;
      end
   end

   // Debounce: Level only moves after 2^debwidth consecutive enabled ticks of disagreement.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Level      <= '0;
         level_prev <= '0;
         for (int i = 0; i < width; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         level_prev <= Level;
         for (int i = 0; i < width; i++) begin
            if (s2[i] == Level[i]) begin
               cnt[i] <= '0;
            end else if (Enable) begin
               if (cnt[i] == deb_full) begin
                  Level[i] <= s2[i];
                  cnt[i]   <= '0;
               end else begin
                  cnt[i] <= cnt[i] + debwidth'(1);
               end
            end
         end
      end
   end

   assign rise = Level & ~level_prev;
   assign fall = ~Level & level_prev;

   // Ownership arbitration: in related mode a rise is accepted only when nobody owns
   // the buttons and no lower-index channel rises in the same cycle.
   always_comb begin
      any_active = 1'b0;
      lower_rise = 1'b0;
      accept     = '0;
      for (int i = 0; i < width; i++) begin
         if (state[i] == ST_PRESSED || state[i] == ST_HELD || state[i] == ST_REPEAT) begin
            any_active = 1'b1;
         end
      end
      for (int i = 0; i < width; i++) begin
         accept[i]  = (related == 0) || (!any_active && !lower_rise);
         lower_rise = lower_rise | rise[i];
      end
   end

   // Per-channel press FSM next state and event decode; a fall always beats a same-cycle tick event.
   always_comb begin
      press_n     = '0;
      release_n   = '0;
      longpress_n = '0;
      repeat_n    = '0;
      active_n    = '0;
      for (int i = 0; i < width; i++) begin
         state_n[i] = state[i];
         hcnt_n[i]  = hcnt[i];
         case (state[i])
            ST_IDLE: begin
               if (rise[i]) begin
                  if (accept[i]) begin
                     press_n[i] = 1'b1;
                     hcnt_n[i]  = '0;
                     state_n[i] = ST_PRESSED;
                  end else begin
                     state_n[i] = ST_LOCKED;
                  end
               end
            end
            ST_LOCKED: begin
               if (fall[i]) begin
                  state_n[i] = ST_IDLE;
               end
            end
            ST_PRESSED: begin
               if (fall[i]) begin
                  release_n[i] = 1'b1;
                  state_n[i]   = ST_IDLE;
               end else if (Enable) begin
                  if (hcnt[i] == hold_last) begin
                     longpress_n[i] = 1'b1;
                     hcnt_n[i]      = '0;
                     state_n[i]     = (repeaten != 0) ? ST_REPEAT : ST_HELD;
                  end else begin
                     hcnt_n[i] = hcnt[i] + holdwidth'(1);
                  end
               end
            end
            ST_HELD: begin
               if (fall[i]) begin
                  release_n[i] = 1'b1;
                  state_n[i]   = ST_IDLE;
               end
            end
            ST_REPEAT: begin
               if (fall[i]) begin
                  release_n[i] = 1'b1;
                  state_n[i]   = ST_IDLE;
               end else if (Enable) begin
                  if (hcnt[i] == repeat_last) begin
                     repeat_n[i] = 1'b1;
                     hcnt_n[i]   = '0;
                  end else begin
                     hcnt_n[i] = hcnt[i] + holdwidth'(1);
                  end
               end
            end
            default: begin
               state_n[i] = ST_IDLE;
               hcnt_n[i]  = '0;
            end
         endcase
         active_n[i] = (state_n[i] == ST_PRESSED) || (state_n[i] == ST_HELD) ||
                       (state_n[i] == ST_REPEAT);
      end
   end

   // State, hold counters and registered event outputs; reset drops everything silently.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < width; i++) begin
            state[i] <= ST_IDLE;
            hcnt[i]  <= '0;
         end
         Active    <= '0;
         Press     <= '0;
         Release   <= '0;
         LongPress <= '0;
         Repeat    <= '0;
      end else begin
         for (int i = 0; i < width; i++) begin
            state[i] <= state_n[i];
            hcnt[i]  <= hcnt_n[i];
         end
         Active    <= active_n;
         Press     <= press_n;
         Release   <= release_n;
         LongPress <= longpress_n;
         Repeat    <= repeat_n;
      end
   end

endmodule

// File: tb/tb_button_event_parser.sv
// Bench for button_event_parser: directed scenarios plus random stimulus against a reference model.
// Latency: model is cycle accurate; outputs sampled 1 time unit after each rising edge.
// Backpressure: none; every pulse is compared on the cycle it appears.
module tb_button_event_parser;

   localparam int W   = 3;
   localparam int DW  = 2;
   localparam int HW  = 8;
   localparam int HT  = 10;
   localparam int RT  = 3;
   localparam int RE  = 1;
   localparam int REL = 1;

   // In sampled at the 1st edge: two sync edges + 2^DW debounce ticks, then one more edge for Press.
   localparam int LVL_LAT   = 2 + (1 << DW);
   localparam int PRESS_LAT = LVL_LAT + 1;

   logic         Clock = 1'b0;
   logic         Reset;
   logic         Enable;
   logic [W-1:0] In;
   logic [W-1:0] Level, Active, Press, Release, LongPress, Repeat;

   int passed = 0;
   int total  = 0;

   // Reference model state: plain integers per channel.
   // mode: 0 = idle, 1 = owns the press (pressed/held/repeat), 2 = locked out.
   int m_s1 [W];
   int m_s2 [W];
   int m_lvl [W];
   int m_prev [W];
   int m_run [W];
   int m_mode [W];
   int m_t [W];
   logic [W-1:0] e_press, e_rel, e_long, e_rep, e_act;

   button_event_parser #(
      .width(W), .debwidth(DW), .holdwidth(HW), .holdticks(HT),
      .repeatticks(RT), .repeaten(RE), .related(REL)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .In(In),
      .Level(Level), .Active(Active), .Press(Press), .Release(Release),
      .LongPress(LongPress), .Repeat(Repeat)
   );

   always #5 Clock = ~Clock;

   // One clock of the specified behaviour, expressed as run lengths and ticks-since-press.
   function automatic void model_update(input logic [W-1:0] inv, input logic en, input logic rst);
      bit any_act;
      bit lower;
      bit rise;
      bit fall;
      e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_act = '0;
      if (rst) begin
         for (int i = 0; i < W; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_prev[i] = 0;
            m_run[i] = 0; m_mode[i] = 0; m_t[i] = 0;
         end
         return;
      end
      any_act = 0;
      for (int i = 0; i < W; i++) if (m_mode[i] == 1) any_act = 1;
      lower = 0;
      for (int i = 0; i < W; i++) begin
         rise = (m_lvl[i] == 1) && (m_prev[i] == 0);
         fall = (m_lvl[i] == 0) && (m_prev[i] == 1);
         if (m_mode[i] == 0) begin
            if (rise) begin
               if (REL == 0 || (!any_act && !lower)) begin
                  e_press[i] = 1'b1; m_mode[i] = 1; m_t[i] = 0;
               end else begin
                  m_mode[i] = 2;
               end
            end
         end else if (m_mode[i] == 2) begin
            if (fall) m_mode[i] = 0;
         end else begin
            if (fall) begin
               e_rel[i] = 1'b1; m_mode[i] = 0;
            end else if (en) begin
               m_t[i]++;
               if (m_t[i] == HT) e_long[i] = 1'b1;
               else if (RE != 0 && m_t[i] > HT && ((m_t[i] - HT) % RT) == 0) e_rep[i] = 1'b1;
            end
         end
         if (rise) lower = 1;
         e_act[i] = (m_mode[i] == 1);
      end
      for (int i = 0; i < W; i++) begin
         m_prev[i] = m_lvl[i];
         if (m_s2[i] == m_lvl[i]) begin
            m_run[i] = 0;
         end else if (en) begin
            m_run[i]++;
            if (m_run[i] == (1 << DW)) begin
               m_lvl[i] = m_s2[i];
               m_run[i] = 0;
            end
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = int'(inv[i]);
      end
   endfunction

   function automatic logic [6*W-1:0] expected();
      logic [W-1:0] lv;
      for (int i = 0; i < W; i++) lv[i] = (m_lvl[i] != 0);
      return {lv, e_act, e_press, e_rel, e_long, e_rep};
   endfunction

   function automatic logic [6*W-1:0] observed();
      return {Level, Active, Press, Release, LongPress, Repeat};
   endfunction

   task automatic step(input logic [W-1:0] inv, input logic en, input logic rst);
      In = inv; Enable = en; Reset = rst;
      @(posedge Clock);
      model_update(inv, en, rst);
      #1;
   endtask

   task automatic test_reset();
      for (int n = 0; n < 3; n++) step('0, 1'b1, 1'b1);
      total++;
      if (observed() !== '0) $display("FAIL reset_outputs got %h want 0", observed());
      else passed++;
      step('0, 1'b1, 1'b0);
      total++;
      if (observed() !== expected()) $display("FAIL reset_model got %h want %h", observed(), expected());
      else passed++;
   endtask

   task automatic test_clean_press_hold();
      for (int n = 1; n <= 30; n++) begin
         step(3'b001, 1'b1, 1'b0);
         total++;
         if (observed() !== expected()) $display("FAIL hold_model n=%0d got %h want %h", n, observed(), expected());
         else passed++;
         if (n == LVL_LAT - 1) begin
            total++;
            if (Level !== 3'b000) $display("FAIL level_early got %b want 000", Level); else passed++;
         end
         if (n == LVL_LAT) begin
            total++;
            if ({Level, Press} !== {3'b001, 3'b000}) $display("FAIL level_rise got %b/%b want 001/000", Level, Press);
            else passed++;
         end
         if (n == PRESS_LAT) begin
            total++;
            if ({Press, Active, Release, LongPress, Repeat} !== {3'b001, 3'b001, 9'b0})
               $display("FAIL press_pulse got P=%b A=%b R=%b L=%b Rp=%b want P=001 A=001", Press, Active, Release, LongPress, Repeat);
            else passed++;
         end
         if (n == PRESS_LAT + 1) begin
            total++;
            if (Press !== 3'b000) $display("FAIL press_one_cycle got %b want 000", Press); else passed++;
         end
         if (n == PRESS_LAT + HT) begin
            total++;
            if (LongPress !== 3'b001) $display("FAIL longpress got %b want 001", LongPress); else passed++;
         end
         if (n == PRESS_LAT + HT + RT || n == PRESS_LAT + HT + 2 * RT) begin
            total++;
            if (Repeat !== 3'b001) $display("FAIL repeat n=%0d got %b want 001", n, Repeat); else passed++;
         end
      end
      for (int n = 1; n <= 12; n++) begin
         step(3'b000, 1'b1, 1'b0);
         total++;
         if (observed() !== expected()) $display("FAIL drop_model n=%0d got %h want %h", n, observed(), expected());
         else passed++;
         if (n == PRESS_LAT) begin
            total++;
            if (Release !== 3'b001) $display("FAIL release got %b want 001", Release); else passed++;
         end
         if (n > PRESS_LAT) begin
            total++;
            if ({Active, Repeat} !== 6'b0) $display("FAIL after_release got A=%b Rp=%b want 000/000", Active, Repeat);
            else passed++;
         end
      end
   endtask

   task automatic test_bounce();
      for (int n = 1; n <= 15; n++) begin
         step((n <= 3) ? 3'b001 : 3'b000, 1'b1, 1'b0);
         total++;
         if ({Level[0], Press[0], Release[0]} !== 3'b000 || observed() !== expected())
            $display("FAIL bounce n=%0d got %h want %h", n, observed(), expected());
         else passed++;
      end
   endtask

   task automatic test_lockout();
      logic [W-1:0] seen;
      logic [W-1:0] pat [5] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b010};
      for (int ph = 0; ph < 5; ph++) begin
         seen = '0;
         for (int n = 1; n <= 12; n++) begin
            step(pat[ph], 1'b1, 1'b0);
            seen |= Press;
            total++;
            if (observed() !== expected()) $display("FAIL lockout_model ph=%0d n=%0d got %h want %h", ph, n, observed(), expected());
            else passed++;
         end
         total++;
         case (ph)
            0: if ({seen, Active} !== {3'b001, 3'b001}) $display("FAIL lock_own got %b/%b want 001/001", seen, Active); else passed++;
            1, 2: if ({seen, Active[1]} !== 4'b0000) $display("FAIL lock_ch1 ph=%0d got %b/%b want 000/0", ph, seen, Active[1]); else passed++;
            3: if (Active !== 3'b000) $display("FAIL lock_idle got %b want 000", Active); else passed++;
            default: if ({seen, Active} !== {3'b010, 3'b010}) $display("FAIL lock_repress got %b/%b want 010/010", seen, Active); else passed++;
         endcase
      end
      for (int n = 1; n <= 12; n++) step(3'b000, 1'b1, 1'b0);
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] seen = '0;
      for (int n = 1; n <= 12; n++) begin
         step(3'b110, 1'b1, 1'b0);
         seen |= Press;
         total++;
         if (observed() !== expected()) $display("FAIL simul_model n=%0d got %h want %h", n, observed(), expected());
         else passed++;
      end
      total++;
      if ({seen, Active, Level} !== {3'b010, 3'b010, 3'b110})
         $display("FAIL simul_winner got P=%b A=%b L=%b want 010/010/110", seen, Active, Level);
      else passed++;
      for (int n = 1; n <= 12; n++) step(3'b000, 1'b1, 1'b0);
   endtask

   task automatic test_enable_reset();
      bit got_rep = 0;
      bit early   = 0;
      // Enable on every 4th edge (n = 4, 8, 12, 16); s2 is high from edge 3, so the 4th tick is edge 16.
      for (int n = 1; n <= 16; n++) begin
         step(3'b001, (n % 4) == 0, 1'b0);
         total++;
         if (observed() !== expected()) $display("FAIL en_model n=%0d got %h want %h", n, observed(), expected());
         else passed++;
         if (n == 15) begin
            total++;
            if (Level[0] !== 1'b0) $display("FAIL en_level_early got %b want 0", Level[0]); else passed++;
         end
      end
      total++;
      if (Level[0] !== 1'b1) $display("FAIL en_level got %b want 1", Level[0]); else passed++;
      for (int n = 1; n <= 60 && !got_rep; n++) begin
         step(3'b001, 1'b1, 1'b0);
         got_rep = (Repeat[0] === 1'b1);
         total++;
         if (observed() !== expected()) $display("FAIL rep_model n=%0d got %h want %h", n, observed(), expected());
         else passed++;
      end
      total++;
      if (!got_rep) $display("FAIL reach_repeat got no Repeat within 60 cycles want Repeat[0]=1"); else passed++;
      step(3'b001, 1'b1, 1'b1);
      total++;
      if (observed() !== '0) $display("FAIL reset_in_repeat got %h want 0", observed()); else passed++;
      for (int n = 1; n <= PRESS_LAT + 1; n++) begin
         step(3'b001, 1'b1, 1'b0);
         if (n < PRESS_LAT && (Press !== 3'b000 || Release !== 3'b000)) early = 1;
         if (n == PRESS_LAT) begin
            total++;
            if (Press !== 3'b001 || early) $display("FAIL repress_after_reset got %b early=%0d want 001 early=0", Press, early);
            else passed++;
         end
      end
      for (int n = 1; n <= 12; n++) step(3'b000, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [W-1:0] inv = '0;
      logic en;
      logic rst;
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < W; i++) if ($urandom_range(0, 19) == 0) inv[i] = ~inv[i];
         en  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 599) == 0);
         step(inv, en, rst);
         total++;
         if (observed() !== expected()) $display("FAIL random_model n=%0d got %h want %h", n, observed(), expected());
         else passed++;
         if (REL != 0 && $countones(Active) > 1) begin
            total++;
            $display("FAIL onehot_active n=%0d got %b want at most one bit", n, Active);
         end
      end
   endtask

   initial begin
      Reset = 1'b1; Enable = 1'b0; In = '0;
      test_reset();
      test_clean_press_hold();
      test_bounce();
      test_lockout();
      test_simultaneous();
      test_enable_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
